// File: rtl/ps2_host_tx_if.sv
// Command-byte request channel into the PS/2 host transmitter.
// Valid/ready: the byte on TX_DATA is taken on a rising CLK where TX_VALID and
// TX_READY are both high; TX_VALID may rise at any time and TX_READY never
// depends combinationally on TX_VALID.
interface ps2_host_tx_if;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked by the
// device, ACK capture, with start/bit timeouts and a glitch-filtered clock input.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int BIT_TIMEOUT    = 100000,
    parameter int FILTER_LEN     = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    ps2_host_tx_if.slave tx,
    input  logic         PS2_CLK_IN,
    input  logic         PS2_DATA_IN,
    output logic         PS2_CLK_OE,
    output logic         PS2_DATA_OE,
    output logic         DONE,
    output logic         ACK_OK,
    output logic         ERR_TIMEOUT,
    output logic [2:0]   STATE_DBG
);

    localparam int CNT_MAX =
        (START_TIMEOUT > BIT_TIMEOUT)
            ? ((START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES)
            : ((BIT_TIMEOUT > INHIBIT_CYCLES) ? BIT_TIMEOUT : INHIBIT_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    // The START cycle also holds the clock low, so INHIBIT itself lasts one
    // cycle less and the total low time is exactly INHIBIT_CYCLES.
    localparam logic [CW-1:0] INH_LOAD   = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] START_LOAD = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] BIT_LOAD   = CW'(BIT_TIMEOUT - 1);
    localparam logic [FW-1:0] FLT_LAST   = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_SEND      = 3'd3,
        S_WAIT_ACK  = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt, clk_fall;
    logic [FW-1:0] flt_cnt;

    state_t        state;
    logic [9:0]    shreg;
    logic [3:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic          rdy;

    assign tx.TX_READY = rdy;
    assign STATE_DBG   = state;

    // Pad synchronizers and clock deglitch; clk_fall marks one filtered 1->0 change.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_filt <= 1'b1;
            clk_fall <= 1'b0;
            flt_cnt  <= '0;
        end else begin
            clk_s1   <= PS2_CLK_IN;
            clk_s2   <= clk_s1;
            dat_s1   <= PS2_DATA_IN;
            dat_s2   <= dat_s1;
            clk_fall <= 1'b0;
            if (clk_s2 == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                flt_cnt  <= '0;
                clk_filt <= clk_s2;
                clk_fall <= ~clk_s2;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bit_idx     <= '0;
            cnt         <= '0;
            rdy         <= 1'b1;
            PS2_CLK_OE  <= 1'b0;
            PS2_DATA_OE <= 1'b0;
            DONE        <= 1'b0;
            ACK_OK      <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
        end else begin
            DONE        <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            case (state)
                S_IDLE: begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    rdy         <= 1'b1;
                    if (tx.TX_VALID && rdy) begin
                        shreg      <= {1'b1, ~^tx.TX_DATA, tx.TX_DATA};
                        bit_idx    <= '0;
                        cnt        <= INH_LOAD;
                        rdy        <= 1'b0;
                        PS2_CLK_OE <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == '0) begin
                        PS2_DATA_OE <= 1'b1;
                        state       <= S_START;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_START: begin
                    PS2_CLK_OE <= 1'b0;
                    cnt        <= START_LOAD;
                    state      <= S_SEND;
                end
                S_SEND: begin
                    if (clk_fall) begin
                        PS2_DATA_OE <= ~shreg[bit_idx];
                        cnt         <= BIT_LOAD;
                        if (bit_idx == 4'd9) begin
                            state <= S_WAIT_ACK;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else if (cnt == '0) begin
                        PS2_DATA_OE <= 1'b0;
                        ERR_TIMEOUT <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    if (clk_fall) begin
                        ACK_OK <= ~dat_s2;
                        cnt    <= BIT_LOAD;
                        state  <= S_WAIT_IDLE;
                    end else if (cnt == '0) begin
                        ERR_TIMEOUT <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    if (clk_filt && dat_s2) begin
                        DONE  <= 1'b1;
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        ERR_TIMEOUT <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    PS2_CLK_OE  <= 1'b0;
                    PS2_DATA_OE <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain pad model plus a PS/2 device model that
// clocks frames at a 40-cycle period, with table-driven and hand-written sequences.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INHIBIT_CYCLES = 20;
  localparam int START_TIMEOUT  = 200;
  localparam int BIT_TIMEOUT    = 100;
  localparam int FILTER_LEN     = 4;
  localparam int HALF_CLK       = 20;
  // pad edge -> 2 sync flops -> FILTER_LEN samples -> edge flag seen by the FSM
  localparam int EDGE_LAT       = 2 + FILTER_LEN + 1;

  typedef struct {
    logic [7:0] data;
    logic       dev_ack;
    logic       glitch;
    logic       hold;
    logic       exp_parity;
    logic       exp_ack_ok;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0, dev_glitch = 1'b0;
  logic       ps2_clk_pad, ps2_data_pad;
  logic       ps2_clk_oe, ps2_data_oe, done, ack_ok, err_timeout;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;
  int done_cnt = 0, err_cnt = 0, hs_cnt = 0, both_cnt = 0;
  logic [10:0] exp_q[$];
  vec_t vecs[6];

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT_CYCLES),
    .START_TIMEOUT (START_TIMEOUT),
    .BIT_TIMEOUT   (BIT_TIMEOUT),
    .FILTER_LEN    (FILTER_LEN)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .tx         (tx_if),
    .PS2_CLK_IN (ps2_clk_pad),
    .PS2_DATA_IN(ps2_data_pad),
    .PS2_CLK_OE (ps2_clk_oe),
    .PS2_DATA_OE(ps2_data_oe),
    .DONE       (done),
    .ACK_OK     (ack_ok),
    .ERR_TIMEOUT(err_timeout),
    .STATE_DBG  (state_dbg)
  );

  // wired-AND open-drain bus
  assign ps2_clk_pad  = ~(ps2_clk_oe | dev_clk_low | dev_glitch);
  assign ps2_data_pad = ~(ps2_data_oe | dev_data_low);

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err_timeout) err_cnt++;
    if (done && err_timeout) both_cnt++;
    if (rst_n && tx_if.TX_VALID && tx_if.TX_READY) hs_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // hand off a byte and return once the DUT has released PS2_CLK
  task automatic request(input logic [7:0] data, input logic hold, output int inh_len);
    tx_if.TX_DATA  = data;
    tx_if.TX_VALID = 1'b1;
    tick();
    if (!hold) tx_if.TX_VALID = 1'b0;
    inh_len = 0;
    while (ps2_clk_oe && inh_len < 1000) begin
      inh_len++;
      tick();
    end
  endtask

  task automatic dev_clock(input int k, input logic glitch);
    dev_clk_low = 1'b1;
    repeat (HALF_CLK) tick();
    dev_clk_low = 1'b0;
    for (int j = 0; j < HALF_CLK; j++) begin
      dev_glitch = glitch && (k == 3 || k == 6) && (j == 5 || j == 6);
      tick();
    end
    dev_glitch = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n, hs0, e0;
    logic [10:0] rx, exp_frame;
    hs0 = hs_cnt;
    e0  = err_cnt;
    exp_q.push_back({1'b1, v.exp_parity, v.data, 1'b0});
    request(v.data, v.hold, n);
    check("inhibit_len", n, INHIBIT_CYCLES);
    rx = '0;
    rx[0] = ps2_data_pad;
    repeat (10) tick();
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF_CLK) tick();
      rx[k] = ps2_data_pad;
      dev_clk_low = 1'b0;
      for (int j = 0; j < HALF_CLK; j++) begin
        dev_glitch = v.glitch && (k == 3 || k == 6) && (j == 5 || j == 6);
        tick();
      end
      dev_glitch = 1'b0;
    end
    dev_data_low = v.dev_ack;
    dev_clk_low  = 1'b1;
    repeat (HALF_CLK) tick();
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    n = 0;
    while (!done && !err_timeout && n < 200) begin
      n++;
      tick();
    end
    check("done_seen", done, 1'b1);
    check("ack_ok", ack_ok, v.exp_ack_ok);
    check("no_timeout_in_frame", err_cnt - e0, 0);
    tx_if.TX_VALID = 1'b0;
    tick();
    check("ready_after_done", tx_if.TX_READY, 1'b1);
    check("single_accept", hs_cnt - hs0, 1);
    exp_frame = exp_q.pop_front();
    check("frame_bits", rx, exp_frame);
    repeat (5) tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, e0, viol;
    //            data   ack   glitch hold  parity ack_ok
    vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    tx_if.TX_DATA  = 8'h00;
    tx_if.TX_VALID = 1'b0;
    repeat (3) tick();
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_ok", ack_ok, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", tx_if.TX_READY, 1'b1);

    // device clocks the bus while the host is idle
    d0 = done_cnt; e0 = err_cnt; viol = 0;
    for (int k = 0; k < 3; k++) begin
      dev_clk_low = 1'b1; dev_data_low = 1'b1;
      for (int j = 0; j < HALF_CLK; j++) begin
        tick();
        if (ps2_clk_oe || ps2_data_oe) viol++;
      end
      dev_clk_low = 1'b0; dev_data_low = 1'b0;
      for (int j = 0; j < HALF_CLK; j++) begin
        tick();
        if (ps2_clk_oe || ps2_data_oe) viol++;
      end
    end
    check("idle_traffic_oe", viol, 0);
    check("idle_traffic_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // device never clocks after release
    d0 = done_cnt;
    request(8'hFF, 1'b0, n);
    check("tmo_inhibit_len", n, INHIBIT_CYCLES);
    n = 0;
    while (!err_timeout && n < 1000) begin
      n++;
      tick();
    end
    check("start_timeout_cycles", n, START_TIMEOUT);
    check("start_tmo_clk_oe", ps2_clk_oe, 1'b0);
    check("start_tmo_data_oe", ps2_data_oe, 1'b0);
    check("start_tmo_ack_held", ack_ok, 1'b1);
    tick();
    check("start_tmo_pulse_len", err_timeout, 1'b0);
    check("start_tmo_no_done", done_cnt - d0, 0);
    repeat (5) tick();

    // device stalls after 5 edges; bit 4 of 0x0F is 0 so DATA_OE is low-driving then
    d0 = done_cnt;
    request(8'h0F, 1'b0, n);
    repeat (10) tick();
    for (int k = 1; k <= 4; k++) dev_clock(k, 1'b0);
    dev_clk_low = 1'b1;
    n = 0; viol = 0;
    while (!err_timeout && n < 1000) begin
      tick();
      n++;
      if (n == HALF_CLK) begin
        viol = ps2_data_oe ? 1 : 0;
        dev_clk_low = 1'b0;
      end
    end
    check("stall_data_oe_before", viol, 1);
    check("bit_timeout_cycles", n, EDGE_LAT + BIT_TIMEOUT);
    check("bit_tmo_clk_oe", ps2_clk_oe, 1'b0);
    viol = 0;
    for (int j = 0; j < 10; j++) begin
      if (ps2_data_oe) viol++;
      tick();
    end
    check("bit_tmo_data_oe_after", viol, 0);
    check("bit_tmo_no_done", done_cnt - d0, 0);

    // reset in the middle of a frame: bit 1 of 0x55 is 0, so DATA_OE is high after edge 2
    d0 = done_cnt; e0 = err_cnt;
    request(8'h55, 1'b0, n);
    repeat (10) tick();
    dev_clock(1, 1'b0);
    dev_clk_low = 1'b1;
    repeat (HALF_CLK) tick();
    check("pre_reset_data_oe", ps2_data_oe, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_clk_oe", ps2_clk_oe, 1'b0);
    check("async_rst_data_oe", ps2_data_oe, 1'b0);
    dev_clk_low = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_mid_reset", tx_if.TX_READY, 1'b1);
    repeat (300) tick();
    check("mid_reset_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    check("mid_reset_oe_idle", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    check("done_err_exclusive", both_cnt, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
